// File: rtl/cue_sequencer_if.sv
// Cue link between the sequencer (master) and the button checker (slave).
// The master presents val with an en strobe; the checker answers with verdict pulses.
interface cue_sequencer_if;
    logic [2:0] val;
    logic       en;
    logic       check_right;
    logic       check_wrong;

    modport master (
        output val,
        output en,
        input  check_right,
        input  check_wrong
    );

    modport slave (
        input  val,
        input  en,
        output check_right,
        output check_wrong
    );
endinterface

// File: rtl/cue_sequencer.sv
// Round sequencer: picks LFSR cues, times the verdict, keeps score and lives.
// Optional SPEEDUP_EN shortens the per-cue timeout after every correct answer.
module cue_sequencer #(
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter int         MIN_TIMEOUT    = 12_500_000,
    parameter int         STEP           = 2_500_000,
    parameter int         LIVES          = 3,
    parameter int         SCORE_W        = 8,
    parameter logic [7:0] SEED           = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    cue_sequencer_if.master    cue,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               playing,
    output logic               game_over
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      TO_FULL    = TW'(TIMEOUT_CYCLES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, PICK, ISSUE, WAIT, RIGHT, MISS, OVER
    } state_t;

    state_t        state;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_next;
    logic [2:0]    code;
    logic [TW-1:0] timer;
    logic [TW-1:0] cur_timeout;
    logic [TW-1:0] dec_timeout;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign code      = (lfsr_next[2:0] == 3'd0) ? 3'd1 : lfsr_next[2:0];

    // Compared in 32 bits so the subtraction can never wrap below the floor.
    always_comb begin
        if (32'(cur_timeout) >= 32'(MIN_TIMEOUT) + 32'(STEP))
            dec_timeout = cur_timeout - TW'(STEP);
        else
            dec_timeout = TW'(MIN_TIMEOUT);
    end

    assign playing   = state inside {PICK, ISSUE, WAIT, RIGHT, MISS};
    assign game_over = (state == OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= SEED;
            timer       <= '0;
            cur_timeout <= TO_FULL;
            score       <= '0;
            lives       <= '0;
            cue.val     <= '0;
            cue.en      <= 1'b0;
        end else begin
            cue.en <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    cue.val <= '0;
                    if (start) begin
                        score       <= '0;
                        lives       <= LIVES_INIT;
                        cur_timeout <= TO_FULL;
                        state       <= PICK;
                    end
                end
                PICK: begin
                    lfsr    <= lfsr_next;
                    cue.val <= code;
                    timer   <= cur_timeout;
                    cue.en  <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    timer <= timer - 1'b1;
                    // Wrong dominates; a right in the expiry cycle still wins.
                    if (cue.check_wrong) begin
                        cue.val <= '0;
                        state   <= MISS;
                    end else if (cue.check_right) begin
                        cue.val <= '0;
                        state   <= RIGHT;
                    end else if (timer == TW'(1)) begin
                        cue.val <= '0;
                        state   <= MISS;
                    end
                end
                RIGHT: begin
                    if (score != SCORE_MAX)
                        score <= score + 1'b1;
                    if (SPEEDUP)
                        cur_timeout <= dec_timeout;
                    state <= PICK;
                end
                MISS: begin
                    lives <= lives - 2'd1;
                    state <= (lives == 2'd1) ? OVER : PICK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
